// File: rtl/vga_scan_gen.sv
// Raster timing generator: divides the system clock to a pixel rate and walks
// horizontal/vertical phase FSMs, producing mutually aligned registered scan outputs.
module vga_scan_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pixel_clk,
    output logic       hs,
    output logic       vs,
    output logic       Blank,
    output logic       sync,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       FrameTick,
    output logic [7:0] FrameCount
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    // Coordinate values at which each phase begins
    localparam logic [9:0] X_FP   = 10'(H_VISIBLE);
    localparam logic [9:0] X_SYNC = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] X_BP   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_FP   = 10'(V_VISIBLE);
    localparam logic [9:0] Y_SYNC = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] Y_BP   = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} h_state_t;
    typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} v_state_t;

    h_state_t         h_state_reg, h_state_next;
    v_state_t         v_state_reg, v_state_next;
    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [9:0]       x_reg, x_next;
    logic [9:0]       y_reg, y_next;
    logic             hs_reg, hs_next;
    logic             vs_reg, vs_next;
    logic             blank_reg, blank_next;
    logic             pclk_reg, pclk_next;
    logic             tick_reg, tick_next;
    logic [7:0]       frame_cnt_reg, frame_cnt_next;
    logic             pixel_en;
    logic             line_end;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            h_state_reg   <= HS_ACT;
            v_state_reg   <= VS_ACT;
            div_cnt_reg   <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            hs_reg        <= 1'b1;
            vs_reg        <= 1'b1;
            blank_reg     <= 1'b1;
            pclk_reg      <= 1'b0;
            tick_reg      <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            h_state_reg   <= h_state_next;
            v_state_reg   <= v_state_next;
            div_cnt_reg   <= div_cnt_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            hs_reg        <= hs_next;
            vs_reg        <= vs_next;
            blank_reg     <= blank_next;
            pclk_reg      <= pclk_next;
            tick_reg      <= tick_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    always_comb begin
        h_state_next   = h_state_reg;
        v_state_next   = v_state_reg;
        x_next         = x_reg;
        y_next         = y_reg;
        line_end       = 1'b0;
        pixel_en       = (div_cnt_reg == DIV_LAST);
        div_cnt_next   = pixel_en ? '0 : div_cnt_reg + 1'b1;

        if (pixel_en) begin
            x_next = (x_reg == X_LAST) ? 10'd0 : x_reg + 10'd1;
            case (h_state_reg)
                HS_ACT:  if (x_next == X_FP)   h_state_next = HS_FP;
                HS_FP:   if (x_next == X_SYNC) h_state_next = HS_SYNC;
                HS_SYNC: if (x_next == X_BP)   h_state_next = HS_BP;
                HS_BP: begin
                    if (x_reg == X_LAST) begin
                        h_state_next = HS_ACT;
                        line_end     = 1'b1;
                    end
                end
                default: h_state_next = HS_ACT;
            endcase
        end

        // The vertical machine only moves at the end of a line
        if (line_end) begin
            y_next = (y_reg == Y_LAST) ? 10'd0 : y_reg + 10'd1;
            case (v_state_reg)
                VS_ACT:  if (y_next == Y_FP)   v_state_next = VS_FP;
                VS_FP:   if (y_next == Y_SYNC) v_state_next = VS_SYNC;
                VS_SYNC: if (y_next == Y_BP)   v_state_next = VS_BP;
                VS_BP:   if (y_reg == Y_LAST)  v_state_next = VS_ACT;
                default: v_state_next = VS_ACT;
            endcase
        end

        // Outputs come from next-state values so they land with the coordinates
        hs_next        = (h_state_next != HS_SYNC);
        vs_next        = (v_state_next != VS_SYNC);
        blank_next     = (h_state_next == HS_ACT) && (v_state_next == VS_ACT);
        pclk_next      = (div_cnt_next >= DIV_HALF);
        tick_next      = line_end && (y_next == Y_FP);
        frame_cnt_next = tick_next ? frame_cnt_reg + 8'd1 : frame_cnt_reg;
    end

    assign pixel_clk  = pclk_reg;
    assign hs         = hs_reg;
    assign vs         = vs_reg;
    assign Blank      = blank_reg;
    assign sync       = 1'b0;
    assign DrawX      = x_reg;
    assign DrawY      = y_reg;
    assign FrameTick  = tick_reg;
    assign FrameCount = frame_cnt_reg;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: three configurations checked every cycle against a
// closed-form raster model driven by cycles elapsed since reset, with random resets.
module tb_vga_scan_gen;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;

    logic       pclk_a, hs_a, vs_a, blank_a, sync_a, tick_a;
    logic [9:0] x_a, y_a;
    logic [7:0] fc_a;
    logic       pclk_b, hs_b, vs_b, blank_b, sync_b, tick_b;
    logic [9:0] x_b, y_b;
    logic [7:0] fc_b;
    logic       pclk_c, hs_c, vs_c, blank_c, sync_c, tick_c;
    logic [9:0] x_c, y_c;
    logic [7:0] fc_c;

    vga_scan_gen dut_full (
        .Clk(clk), .Reset(rst_a), .pixel_clk(pclk_a), .hs(hs_a), .vs(vs_a),
        .Blank(blank_a), .sync(sync_a), .DrawX(x_a), .DrawY(y_a),
        .FrameTick(tick_a), .FrameCount(fc_a)
    );

    vga_scan_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(4)
    ) dut_small (
        .Clk(clk), .Reset(rst_b), .pixel_clk(pclk_b), .hs(hs_b), .vs(vs_b),
        .Blank(blank_b), .sync(sync_b), .DrawX(x_b), .DrawY(y_b),
        .FrameTick(tick_b), .FrameCount(fc_b)
    );

    vga_scan_gen #(
        .H_VISIBLE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_VISIBLE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(2)
    ) dut_tiny (
        .Clk(clk), .Reset(rst_c), .pixel_clk(pclk_c), .hs(hs_c), .vs(vs_c),
        .Blank(blank_c), .sync(sync_c), .DrawX(x_c), .DrawY(y_c),
        .FrameTick(tick_c), .FrameCount(fc_c)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int n_a = 0, n_b = 0, n_c = 0;
    int cyc = 0;
    int last_tick_b = -1;
    int ticks_c = 0;
    bit checking = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected {pixel_clk,hs,vs,Blank,sync,DrawX,DrawY,FrameTick,FrameCount}
    // after n clock edges since reset release.
    function automatic logic [33:0] ref_out(input int n,
                                            input int hv, input int hfp, input int hsy, input int hbp,
                                            input int vv, input int vfp, input int vsy, input int vbp,
                                            input int cd);
        int ht, vt, p, x, y, fpix, start, fc;
        logic pc, h, v, b, t;
        ht    = hv + hfp + hsy + hbp;
        vt    = vv + vfp + vsy + vbp;
        p     = n / cd;
        x     = p % ht;
        y     = (p / ht) % vt;
        fpix  = ht * vt;
        start = vv * ht;
        pc    = ((n % cd) >= cd / 2);
        h     = !(x >= hv + hfp && x < hv + hfp + hsy);
        v     = !(y >= vv + vfp && y < vv + vfp + vsy);
        b     = (x < hv) && (y < vv);
        fc    = (p >= start) ? (((p - start) / fpix) + 1) % 256 : 0;
        t     = (n > 0) && (n % cd == 0) && (p % fpix == start);
        return {pc, h, v, b, 1'b0, 10'(x), 10'(y), t, 8'(fc)};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        n_a <= rst_a ? 0 : n_a + 1;
        n_b <= rst_b ? 0 : n_b + 1;
        n_c <= rst_c ? 0 : n_c + 1;
    end

    always @(negedge clk) begin
        if (checking) begin
            check("full",  {pclk_a, hs_a, vs_a, blank_a, sync_a, x_a, y_a, tick_a, fc_a},
                  ref_out(rst_a ? 0 : n_a, 640, 16, 96, 48, 480, 10, 2, 33, 2));
            check("small", {pclk_b, hs_b, vs_b, blank_b, sync_b, x_b, y_b, tick_b, fc_b},
                  ref_out(rst_b ? 0 : n_b, 8, 2, 2, 2, 4, 1, 1, 1, 4));
            check("tiny",  {pclk_c, hs_c, vs_c, blank_c, sync_c, x_c, y_c, tick_c, fc_c},
                  ref_out(rst_c ? 0 : n_c, 4, 1, 1, 1, 2, 1, 1, 1, 2));
            if (rst_b) begin
                last_tick_b = -1;
            end else if (tick_b) begin
                if (last_tick_b >= 0) check("small_tick_gap", 64'(cyc - last_tick_b), 64'd392);
                last_tick_b = cyc;
            end
            if (!rst_c && tick_c) ticks_c++;
        end
    end

    initial begin
        int wait_cyc, len, sel, dly;
        @(posedge clk);
        checking = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #3;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        $display("[TB] release all resets at cycle %0d", cyc);

        // Asynchronous reset mid-line on the full-size instance
        repeat (1000) @(posedge clk);
        @(negedge clk);
        #3;
        rst_a = 1'b1;
        #1;
        check("rst_async", {pclk_a, hs_a, vs_a, blank_a, sync_a, x_a, y_a, tick_a, fc_a},
              {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 8'd0});
        $display("[TB] async reset full at cycle %0d", cyc);
        @(negedge clk);
        #3;
        rst_a = 1'b0;
        @(posedge clk);
        #1;
        check("release_edge1_x", 64'(x_a), 64'd0);
        @(posedge clk);
        #1;
        check("release_edge2_x", 64'(x_a), 64'd1);

        for (int i = 0; i < 8; i++) begin
            wait_cyc = $urandom_range(3000, 5000);
            len      = $urandom_range(1, 3);
            sel      = $urandom_range(0, 1);
            dly      = $urandom_range(1, 8);
            repeat (wait_cyc) @(posedge clk);
            @(negedge clk);
            #(dly);
            if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
            repeat (len) @(posedge clk);
            @(negedge clk);
            #3;
            rst_a = 1'b0;
            rst_b = 1'b0;
            $display("[TB] reset %s at cycle %0d for %0d cycles", (sel == 0) ? "full" : "small", cyc, len);
        end

        repeat (200) @(posedge clk);
        @(negedge clk);
        #2;
        check("tiny_frames_seen", 64'(ticks_c >= 256), 64'd1);
        check("tiny_framecount", 64'(fc_c), 64'(ticks_c % 256));
        $display("[TB] tiny instance completed %0d frames", ticks_c);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
